seven_segment_reader: RTL and testbench
=======================================

// Module: seven_segment_reader
// PURPOSE
//  Receive end of the multiplexed 7-segment display bus. Samples the active-low segment
//  and anode lines, waits for each anode dwell to settle, and decodes each glyph back to a
//  4-bit code. Assembles one frame of NUM_DIGITS codes and hands it off with valid/ready.
//  Used for loopback self-test of display drivers and for capturing external display boards.
// PARAMETERS
//  NUM_DIGITS     4  digit positions, one anode line each
//  SETTLE_CYCLES  4  consecutive stable synchronized samples required before a capture, >=1
//  SYNC_STAGES    2  synchronizer depth on segment/anode inputs, >=2
// PORTS
//  clk          in   1             system clock, all logic rising-edge
//  rst_n        in   1             asynchronous active-low reset
//  segment      in   8             bit7 = DP, bits6:0 = g..a; all active-low; asynchronous
//  anode        in   NUM_DIGITS    digit select, active-low one-hot; asynchronous
//  digits       out  4*NUM_DIGITS  decoded codes; digit i at [4i+3:4i]
//  dp           out  NUM_DIGITS    decimal point per digit, 1 = lit
//  glyph_err    out  NUM_DIGITS    1 = pattern on digit i not in the glyph table
//  frame_valid  out  1             frame available; held until accepted
//  frame_ready  in   1             consumer accept; transfer when frame_valid && frame_ready
//  overrun      out  1             sticky: a completed frame was dropped
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, stable counter 0, seen mask 0, staging regs 0.
//  - Inputs pass through SYNC_STAGES flops; decode and the FSM use only synchronized values.
//  - FSM: IDLE -> SETTLE when the anode is exactly one-hot low. Counter clears on entry.
//    SETTLE: counter increments when {anode,segment} equals the previous cycle's value and
//    clears on any change. Capture happens on the cycle the counter reaches SETTLE_CYCLES.
//    SETTLE -> WAIT_CHG on capture. WAIT_CHG: no further capture until the anode changes.
//    From any state, an anode that is not one-hot (all high = blanking, or several low)
//    -> IDLE. A change to a different one-hot value -> SETTLE.
//  - Capture: write the decoded code, DP and error to staging slot i, then set seen[i].
//    A recapture of the same position before the frame completes overwrites slot i.
//  - Latency: SYNC_STAGES+SETTLE_CYCLES clocks from the input edge to the capture.
//  - Glyph table (segment[6:0], 0 = lit) -> code:
//    0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000
//    8:0000000 9:0011000 A:0001000 B:0000011 C:1100011(U) D:1111111(blank) F:0001110.
//    The S glyph equals 5 and decodes as 5. Code E is never produced.
//    Any other pattern: code 0, glyph_err bit = 1.
//  - Frame complete: seen == all ones.
//    If !frame_valid or a transfer happens this cycle: load digits/dp/glyph_err from staging,
//    set frame_valid on the next cycle, clear seen.
//    Else: drop the new frame, keep the outputs, set overrun, clear seen.
//  - Transfer clears frame_valid on the next cycle unless a new frame loads the same cycle.
//    overrun clears only on a transfer; a drop in the same cycle as a transfer keeps it 1.
//  - Outputs are registered. digits/dp/glyph_err stay stable while frame_valid = 1.
//  - Reset mid-dwell or mid-frame discards partial staging; no frame is emitted.
// CONFIGURATION
//  SEVSEG_READER_DP_EN defined: dp[i] = ~segment[7] at capture.
//  SEVSEG_READER_DP_EN not defined: dp is tied 0, segment[7] is ignored, and no DP staging
//  flops are built. Decode uses bits 6:0 in both cases.
// STRUCTURE
//  Package sevseg_pkg: glyph pattern localparams, the code constants above, and the FSM
//  state enum {IDLE, SETTLE, WAIT_CHG}.
//  Sub-module sevseg_glyph_decode: combinational segment[6:0] -> {code[3:0], err}.
//  Shared with future display blocks.
// TESTING
//  1. Scan anodes 1110,1101,1011,0111 with glyphs 1,2,3,4; 8-clk dwell; ready=1
//     -> frame_valid pulses 1 clk, digits=16'h4321, glyph_err=0.
//  2. Digit 0 shows 0010010 (S) -> code 5. Digit 1 shows 1111110 -> code 0, glyph_err[1]=1.
//  3. Dwell of 3 clks with SETTLE_CYCLES=4 -> no capture, no frame.
//     Glitch a segment mid-dwell -> capture delayed by a full settle window.
//  4. ready=0 for two full scans -> first frame held unchanged, second dropped, overrun=1.
//     Then ready=1 -> transfer, overrun=0.
//  5. Anode 1100 or 1111 between dwells -> IDLE, no capture. Assert rst_n low mid-scan
//     -> all outputs 0, next frame needs all four positions again.
//  6. With SEVSEG_READER_DP_EN, DP lit on digit 2 -> dp=4'b0100. Without the macro -> dp=0.

Source files
------------

// File: rtl/sevseg_pkg.sv
// Shared definitions for the 7-segment display reader: glyph patterns (active-low,
// bits 6:0 = g..a), decoded code values and the capture FSM state type.
package sevseg_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0011000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_U     = 7'b1100011;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;

  // U and blank reuse the otherwise unused hex codes; E is never produced.
  localparam logic [3:0] CODE_U     = 4'hC;
  localparam logic [3:0] CODE_BLANK = 4'hD;
  localparam logic [3:0] CODE_F     = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'h0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    WAIT_CHG = 2'd2
  } state_e;

endpackage

// File: rtl/sevseg_glyph_decode.sv
// Combinational glyph decoder: active-low segment pattern -> 4-bit code plus error flag.
module sevseg_glyph_decode
  import sevseg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = CODE_ERR;
    err  = 1'b0;
    case (seg_n)
      GLYPH_0:     code = 4'h0;
      GLYPH_1:     code = 4'h1;
      GLYPH_2:     code = 4'h2;
      GLYPH_3:     code = 4'h3;
      GLYPH_4:     code = 4'h4;
      GLYPH_5:     code = 4'h5;  // S glyph is identical to 5
      GLYPH_6:     code = 4'h6;
      GLYPH_7:     code = 4'h7;
      GLYPH_8:     code = 4'h8;
      GLYPH_9:     code = 4'h9;
      GLYPH_A:     code = 4'hA;
      GLYPH_B:     code = 4'hB;
      GLYPH_U:     code = CODE_U;
      GLYPH_BLANK: code = CODE_BLANK;
      GLYPH_F:     code = CODE_F;
      default:     err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Receive side of a multiplexed 7-segment bus: syncs, waits for each dwell to settle,
// decodes glyphs and hands off full frames. Define SEVSEG_READER_DP_EN to capture DP.
module seven_segment_reader
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              segment,
  input  logic [NUM_DIGITS-1:0]   anode,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   glyph_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);

`ifdef SEVSEG_READER_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
  logic unused_dp;
  assign unused_dp = segment[7];
`endif
  localparam int IN_W = NUM_DIGITS + SEG_W;
  localparam int CW   = $clog2(SETTLE_CYCLES + 1);

  // ---- input synchronizer ----
  logic [SYNC_STAGES-1:0][IN_W-1:0] sync_q, sync_d;
  logic [IN_W-1:0]       in_s, prev_q, prev_d;
  logic [NUM_DIGITS-1:0] an_s, an_low;
  logic [SEG_W-1:0]      seg_s;

  always_comb begin
    sync_d[0] = {anode, segment[SEG_W-1:0]};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign in_s   = sync_q[SYNC_STAGES-1];
  assign an_s   = in_s[IN_W-1:SEG_W];
  assign seg_s  = in_s[SEG_W-1:0];
  assign an_low = ~an_s;
  assign prev_d = in_s;

  logic an_ok, an_chg, same;
  assign an_ok  = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
  assign an_chg = an_s != prev_q[IN_W-1:SEG_W];
  assign same   = in_s == prev_q;

  // ---- capture FSM ----
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!an_ok) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:     state_d = SETTLE;
        SETTLE:   if (capture) state_d = WAIT_CHG;
        WAIT_CHG: if (an_chg)  state_d = SETTLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    capture = 1'b0;
    cnt_d   = '0;
    if (state_q == SETTLE && same) begin
      cnt_d   = cnt_inc;
      capture = an_ok && (cnt_inc == CW'(SETTLE_CYCLES));
    end
  end

  // ---- decode and staging ----
  logic [3:0] dec_code;
  logic       dec_err;

  sevseg_glyph_decode u_dec (
    .seg_n (seg_s[6:0]),
    .code  (dec_code),
    .err   (dec_err)
  );

  logic [NUM_DIGITS-1:0]      cap_mask, seen_q, seen_d;
  logic [NUM_DIGITS-1:0][3:0] stg_code_q, stg_code_d;
  logic [NUM_DIGITS-1:0]      stg_err_q, stg_err_d;
  logic frame_done, xfer, load, drop;

  assign cap_mask   = capture ? an_low : '0;
  assign frame_done = &seen_q;
  assign xfer       = frame_valid & frame_ready;
  assign load       = frame_done & (~frame_valid | xfer);
  assign drop       = frame_done & frame_valid & ~frame_ready;

  always_comb begin
    stg_code_d = stg_code_q;
    stg_err_d  = stg_err_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap_mask[i]) begin
        stg_code_d[i] = dec_code;
        stg_err_d[i]  = dec_err;
      end
    end
    // A capture landing on the completion cycle starts the next frame.
    seen_d = (frame_done ? '0 : seen_q) | cap_mask;
  end

  // ---- output registers ----
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    fv_q, fv_d, ov_q, ov_d;

  always_comb begin
    digits_d = load ? stg_code_q : digits_q;
    err_d    = load ? stg_err_q  : err_q;
    fv_d     = load ? 1'b1 : (xfer ? 1'b0 : fv_q);
    ov_d     = drop ? 1'b1 : (xfer ? 1'b0 : ov_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      seen_q     <= '0;
      stg_code_q <= '0;
      stg_err_q  <= '0;
      digits_q   <= '0;
      err_q      <= '0;
      fv_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      stg_code_q <= stg_code_d;
      stg_err_q  <= stg_err_d;
      digits_q   <= digits_d;
      err_q      <= err_d;
      fv_q       <= fv_d;
      ov_q       <= ov_d;
    end
  end

`ifdef SEVSEG_READER_DP_EN
  logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d, dp_q, dp_d;

  always_comb begin
    stg_dp_d = stg_dp_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (cap_mask[i]) stg_dp_d[i] = ~seg_s[7];
    dp_d = load ? stg_dp_q : dp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_dp_q <= '0;
      dp_q     <= '0;
    end else begin
      stg_dp_q <= stg_dp_d;
      dp_q     <= dp_d;
    end
  end

  assign dp = dp_q;
`else
  assign dp = '0;
`endif

  assign digits      = digits_q;
  assign glyph_err   = err_q;
  assign frame_valid = fv_q;
  assign overrun     = ov_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader: table-driven frame scans plus hand-written
// sequences for settle timing, glitches, invalid anodes, overrun and mid-scan reset.
module tb_seven_segment_reader;

  localparam logic [7:0] P_0 = 8'hC0, P_1 = 8'hF9, P_2 = 8'hA4, P_3 = 8'hB0;
  localparam logic [7:0] P_4 = 8'h99, P_5 = 8'h92, P_6 = 8'h82, P_7 = 8'hF8;
  localparam logic [7:0] P_8 = 8'h80, P_9 = 8'h98, P_A = 8'h88, P_B = 8'h83;
  localparam logic [7:0] P_U = 8'hE3, P_BLANK = 8'hFF, P_F = 8'h8E, P_BAD = 8'hFE;
  localparam logic [7:0] P_S = 8'h92;
  localparam logic [7:0] P_B_DP = 8'h03;
`ifdef SEVSEG_READER_DP_EN
  localparam logic [3:0] DP2_EXP = 4'b0100;
`else
  localparam logic [3:0] DP2_EXP = 4'b0000;
`endif

  logic        clk, rst_n;
  logic [7:0]  segment;
  logic [3:0]  anode;
  logic [15:0] digits;
  logic [3:0]  dp, glyph_err;
  logic        frame_valid, frame_ready, overrun;

  seven_segment_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .segment     (segment),
    .anode       (anode),
    .digits      (digits),
    .dp          (dp),
    .glyph_err   (glyph_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer monitor, sampled mid-cycle.
  int          xfer_cnt = 0;
  int          fv_cyc   = 0;
  int          last_cyc = 0;
  logic [15:0] last_dig = '0;
  logic [3:0]  last_err = '0;
  logic [3:0]  last_dp  = '0;

  always @(negedge clk) begin
    if (frame_valid) fv_cyc <= fv_cyc + 1;
    if (frame_valid && frame_ready) begin
      xfer_cnt <= xfer_cnt + 1;
      last_dig <= digits;
      last_err <= glyph_err;
      last_dp  <= dp;
      last_cyc <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic show(input int d, input logic [7:0] pat, input int dwell);
    logic [3:0] one;
    one     = 4'b0001 << d;
    anode   = ~one;
    segment = pat;
    tick(dwell);
  endtask

  task automatic blank(input int n);
    anode   = 4'hF;
    segment = P_BLANK;
    tick(n);
  endtask

  task automatic scan(input logic [3:0][7:0] pats, input int dwell, output int t_last);
    t_last = 0;
    for (int d = 0; d < 4; d++) begin
      if (d == 3) begin
        anode   = 4'b0111;
        segment = pats[3];
        t_last  = cyc;
        tick(dwell);
      end else begin
        show(d, pats[d], dwell);
      end
    end
    blank(6);
  endtask

  typedef struct {
    logic [3:0][7:0] seg;
    logic [15:0]     digits;
    logic [3:0]      err;
    logic [3:0]      dp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int x0, f0, t0;
    vecs[0] = '{seg: {P_4, P_3, P_2, P_1},      digits: 16'h4321, err: 4'b0000, dp: 4'b0000};
    vecs[1] = '{seg: {P_BLANK, P_A, P_BAD, P_S}, digits: 16'hDA05, err: 4'b0010, dp: 4'b0000};
    vecs[2] = '{seg: {P_F, P_B_DP, P_U, P_0},   digits: 16'hFBC0, err: 4'b0000, dp: DP2_EXP};
    vecs[3] = '{seg: {P_9, P_8, P_7, P_6},      digits: 16'h9876, err: 4'b0000, dp: 4'b0000};

    rst_n = 1'b0; anode = 4'hF; segment = P_BLANK; frame_ready = 1'b0;
    tick(3);
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_err", 32'(glyph_err), 32'h0);
    check("rst_valid", 32'(frame_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Table: full scans with ready high, 8-clock dwell.
    frame_ready = 1'b1;
    foreach (vecs[v]) begin
      x0 = xfer_cnt; f0 = fv_cyc;
      scan(vecs[v].seg, 8, t0);
      check($sformatf("v%0d_xfer", v), 32'(xfer_cnt - x0), 32'd1);
      check($sformatf("v%0d_pulse", v), 32'(fv_cyc - f0), 32'd1);
      check($sformatf("v%0d_digits", v), 32'(last_dig), 32'(vecs[v].digits));
      check($sformatf("v%0d_err", v), 32'(last_err), 32'(vecs[v].err));
      check($sformatf("v%0d_dp", v), 32'(last_dp), 32'(vecs[v].dp));
      check($sformatf("v%0d_latency", v), 32'(last_cyc - t0), 32'd8);
    end

    // Dwell shorter than the settle window: nothing captured.
    x0 = xfer_cnt;
    scan({P_8, P_8, P_8, P_8}, 3, t0);
    blank(10);
    check("short_dwell_noframe", 32'(xfer_cnt - x0), 32'd0);

    // Segment glitch on the last digit restarts the settle window.
    x0 = xfer_cnt;
    show(0, P_1, 8); show(1, P_2, 8); show(2, P_3, 8);
    anode = 4'b0111; segment = P_4; t0 = cyc;
    tick(2); segment = P_9; tick(1); segment = P_4; tick(14);
    blank(4);
    check("glitch_xfer", 32'(xfer_cnt - x0), 32'd1);
    check("glitch_digits", 32'(last_dig), 32'h4321);
    check("glitch_latency", 32'(last_cyc - t0), 32'd11);

    // Multi-hot and blank anodes between dwells capture nothing.
    x0 = xfer_cnt;
    show(2, P_3, 8); show(3, P_4, 8);
    anode = 4'b1100; segment = P_9; tick(10);
    blank(5);
    show(0, P_1, 8); show(1, P_2, 8);
    blank(6);
    check("multihot_xfer", 32'(xfer_cnt - x0), 32'd1);
    check("multihot_digits", 32'(last_dig), 32'h4321);

    // Backpressure: first frame held, second dropped, overrun until transfer.
    frame_ready = 1'b0;
    x0 = xfer_cnt;
    scan({P_4, P_3, P_2, P_1}, 8, t0);
    check("hold_valid", 32'(frame_valid), 32'd1);
    check("hold_digits", 32'(digits), 32'h4321);
    check("hold_overrun", 32'(overrun), 32'd0);
    scan({P_8, P_7, P_6, P_5}, 8, t0);
    check("drop_valid", 32'(frame_valid), 32'd1);
    check("drop_digits", 32'(digits), 32'h4321);
    check("drop_overrun", 32'(overrun), 32'd1);
    frame_ready = 1'b1;
    tick(1);
    check("accept_xfer", 32'(xfer_cnt - x0), 32'd1);
    check("accept_digits", 32'(last_dig), 32'h4321);
    check("accept_valid", 32'(frame_valid), 32'd0);
    check("accept_overrun", 32'(overrun), 32'd0);

    // Reset mid-scan discards the partial frame.
    show(0, P_1, 8); show(1, P_2, 8); show(2, P_3, 8);
    rst_n = 1'b0; anode = 4'hF; segment = P_BLANK;
    tick(2);
    check("midrst_digits", 32'(digits), 32'h0);
    check("midrst_valid", 32'(frame_valid), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick(2);
    x0 = xfer_cnt;
    show(3, P_4, 8);
    blank(10);
    check("midrst_noframe", 32'(xfer_cnt - x0), 32'd0);
    // Slot 3 holds 4 from above; slot 0 is overwritten 9 -> 5 before completion.
    show(0, P_9, 8); show(1, P_6, 8); show(0, P_5, 8); show(2, P_7, 8);
    blank(6);
    check("overwrite_xfer", 32'(xfer_cnt - x0), 32'd1);
    check("overwrite_digits", 32'(last_dig), 32'h4765);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
